seven_seg_scanner: RTL and testbench

//   Time-multiplexed hex display driver for the core's display_reg output.

---
 rtl/seven_seg_scanner.sv | 140 ++++++++++++++
 tb/tb_seven_seg_scanner.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
//   Time-multiplexed hex display driver for a common-anode 7-segment bank.
//   Scans DIGITS hex nibbles of a 32-bit word, one digit lit per slot.
//   Each slot begins with a short all-anodes-off gap to suppress ghosting.
//   Leading-zero suppression is optional.
//   The displayed word comes from a shadow register. The shadow loads only
//   at the frame wrap, so a frame never mixes two values.
// Ports
//   clk       in   system clock
//   reset     in   asynchronous, active-high reset
//   value     in   32-bit word to display (sampled only at frame wrap)
//   blank_lz  in   1 = suppress leading zero digits (live)
//   dp_mask   in   per-digit decimal point enable (live)
//   an        out  anode enables, active-low (one-hot-low or all ones)
//   seg       out  cathodes {g,f,e,d,c,b,a}, active-low
//   dp        out  decimal-point cathode, active-low
module seven_seg_scanner #(
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       value,
  input  logic              blank_lz,
  input  logic [DIGITS-1:0] dp_mask,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg,
  output logic              dp
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [31:0]       shadow_q, shadow_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;

  logic              tick;
  logic [3:0]        nib;
  logic              lz_zero;   // current digit and all digits above it are zero
  logic              run_zero;
  logic              dp_sel;

  function automatic logic [6:0] hex_decode(input logic [3:0] n);
    case (n)
      4'h0: hex_decode = 7'h40;
      4'h1: hex_decode = 7'h79;
      4'h2: hex_decode = 7'h24;
      4'h3: hex_decode = 7'h30;
      4'h4: hex_decode = 7'h19;
      4'h5: hex_decode = 7'h12;
      4'h6: hex_decode = 7'h02;
      4'h7: hex_decode = 7'h78;
      4'h8: hex_decode = 7'h00;
      4'h9: hex_decode = 7'h10;
      4'hA: hex_decode = 7'h08;
      4'hB: hex_decode = 7'h03;
      4'hC: hex_decode = 7'h46;
      4'hD: hex_decode = 7'h21;
      4'hE: hex_decode = 7'h06;
      default: hex_decode = 7'h0E;
    endcase
  endfunction

  assign tick = (cnt_q == CW'(REFRESH_DIV - 1));

  // Scan counters and frame-wrap shadow load.
  always_comb begin
    cnt_d    = cnt_q + CW'(1);
    idx_d    = idx_q;
    shadow_d = shadow_q;
    if (tick) begin
      cnt_d = '0;
      if (idx_q == IW'(DIGITS - 1)) begin
        idx_d    = '0;
        shadow_d = value;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
  end

  // Select the current nibble and its decimal point in one pass. The pass
  // walks from the top digit down, so run_zero tracks whether this digit and
  // every digit above it are zero.
  always_comb begin
    nib      = 4'h0;
    lz_zero  = 1'b0;
    run_zero = 1'b1;
    dp_sel   = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run_zero = run_zero & (shadow_q[4*i +: 4] == 4'h0);
      if (IW'(i) == idx_q) begin
        nib     = shadow_q[4*i +: 4];
        lz_zero = run_zero;
        dp_sel  = dp_mask[i];
      end
    end
  end

  // Output stage: registered, one cycle behind (index, count, shadow).
  always_comb begin
    an_d  = ~(DIGITS'(1) << idx_q);
    seg_d = hex_decode(nib);
    dp_d  = ~dp_sel;
    if (int'(cnt_q) < BLANK_CYC) begin
      an_d = '1;
    end
    if (blank_lz && (idx_q != '0) && lz_zero) begin
      seg_d = 7'h7F;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      an_q     <= '1;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner
//   Self-checking bench for seven_seg_scanner with DIGITS=8, REFRESH_DIV=4
//   and BLANK_CYC=1. The scoreboard model computes the expected registered
//   {an, seg, dp} for every clock edge. Directed frame checks use constant
//   tables.
module tb_seven_seg_scanner;

  logic        clk;
  logic        reset;
  logic [31:0] value;
  logic        blank_lz;
  logic [7:0]  dp_mask;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] exp_q[$];

  // Reference model state
  int          m_cnt;
  int          m_idx;
  logic [31:0] m_shadow;

  // Per-slot observations from the last run_frame
  logic [6:0] obs_seg[8];
  logic [7:0] obs_an0[8];
  logic [7:0] obs_an2[8];
  logic       obs_dp[8];

  logic [6:0] hex_tbl[16];

  seven_seg_scanner #(
    .DIGITS(8),
    .REFRESH_DIV(4),
    .BLANK_CYC(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .value(value),
    .blank_lz(blank_lz),
    .dp_mask(dp_mask),
    .an(an),
    .seg(seg),
    .dp(dp)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_out();
    logic [31:0] sh;
    logic [6:0]  s;
    logic [7:0]  a;
    logic        d;
    sh = m_shadow >> (4 * m_idx);
    s  = hex_tbl[sh[3:0]];
    if (blank_lz && m_idx > 0 && sh == 32'h0) s = 7'h7F;
    a  = (m_cnt < 1) ? 8'hFF : ~(8'h01 << m_idx);
    d  = ~dp_mask[m_idx];
    return {a, s, d};
  endfunction

  task automatic model_reset();
    m_cnt    = 0;
    m_idx    = 0;
    m_shadow = 32'h0;
    exp_q.delete();
  endtask

  // One clock: push the expected output, advance the model, then compare
  // 1 time unit after the edge.
  task automatic step();
    logic [15:0] e;
    exp_q.push_back(model_out());
    if (m_cnt == 3) begin
      m_cnt = 0;
      if (m_idx == 7) begin
        m_idx    = 0;
        m_shadow = value;
      end else begin
        m_idx++;
      end
    end else begin
      m_cnt++;
    end
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("sb_empty", 16'h0, 16'h1);
    end else begin
      e = exp_q.pop_front();
      check("sb", {an, seg, dp}, e);
    end
  endtask

  // Runs one full frame from slot 0.
  // If chg_at >= 0, value becomes new_val at the start of that slot.
  task automatic run_frame(input int chg_at, input logic [31:0] new_val);
    for (int d = 0; d < 8; d++) begin
      for (int c = 0; c < 4; c++) begin
        if (d == chg_at && c == 0) value = new_val;
        step();
        if (c == 0) obs_an0[d] = an;
        if (c == 2) begin
          obs_seg[d] = seg;
          obs_an2[d] = an;
          obs_dp[d]  = dp;
        end
      end
    end
  endtask

  task automatic check_segs(input string tag, input logic [6:0] e[8]);
    for (int d = 0; d < 8; d++) begin
      check(tag, {9'h0, obs_seg[d]}, {9'h0, e[d]});
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check(tag, {an, seg, dp}, {8'hFF, 7'h7F, 1'b1});
  endtask

  initial begin
    hex_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    reset    = 1'b1;
    value    = 32'h0;
    blank_lz = 1'b0;
    dp_mask  = 8'h00;
    model_reset();

    // 1. Reset held 10 cycles, then release; first frame shows shadow=0.
    repeat (10) begin
      @(posedge clk);
      #1;
      check_reset_outs("rst_hold");
    end
    value = 32'h89ABCDEF;
    reset = 1'b0;
    run_frame(-1, 32'h0);
    check("rel_an_cnt0", {8'h0, obs_an0[0]}, 16'h00FF);
    check("rel_an_cnt2", {8'h0, obs_an2[0]}, 16'h00FE);
    check_segs("f1_zero", '{7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40});

    // 2. Second frame shows 89ABCDEF.
    run_frame(-1, 32'h0);
    check_segs("f2_hex", '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00});
    for (int d = 0; d < 8; d++) begin
      check("f2_an", {8'h0, obs_an2[d]}, {8'h0, ~(8'h01 << d)});
    end

    // 3. Mid-frame value change does not tear the frame.
    run_frame(0, 32'h12345678);
    run_frame(3, 32'h0000FFFF);
    check_segs("f4_notear", '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79});
    run_frame(0, 32'h00000A00);
    check_segs("f5_new", '{7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h40, 7'h40, 7'h40, 7'h40});

    // 4. Leading-zero blanking.
    blank_lz = 1'b1;
    run_frame(0, 32'h0);
    check_segs("f6_lz", '{7'h40, 7'h40, 7'h08, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F});
    run_frame(-1, 32'h0);
    check_segs("f7_lz0", '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F});

    // 5. Decimal points and the blanking gap.
    dp_mask = 8'h05;
    run_frame(0, $urandom_range(0, 32'hFFFF) << 16);
    for (int d = 0; d < 8; d++) begin
      check("f8_dp", {15'h0, obs_dp[d]}, {15'h0, (d == 0 || d == 2) ? 1'b0 : 1'b1});
      check("f8_gap", {8'h0, obs_an0[d]}, 16'h00FF);
    end

    // 6. Reset pulse during digit 5.
    dp_mask = 8'h00;
    for (int k = 0; k < 21; k++) step();
    reset = 1'b1;
    #1;
    check_reset_outs("rst_async");
    model_reset();
    repeat (3) begin
      @(posedge clk);
      #1;
      check_reset_outs("rst_mid_hold");
    end
    reset = 1'b0;
    run_frame(-1, 32'h0);
    check("post_rst_seg0", {9'h0, obs_seg[0]}, 16'h0040);
    check("post_rst_an0", {8'h0, obs_an2[0]}, 16'h00FE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
